// File: rtl/output_holder.sv
// Elastic byte FIFO between the encryption block and the off-chip reader; optional sticky drop flag via OUTPUT_HOLDER_OVERFLOW_EN.
// Latency: a push at edge N is visible after N; an ack pin rise before E1 commits its pop at E3. No backpressure; bytes arriving while full are dropped.
module output_holder #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [7:0]       encrypted_byte_in,
    input  logic             encrypted_byte_pulse_in,
    input  logic             read_ack_in,
    output logic [7:0]       byte_out,
    output logic             byte_valid_out,
    output logic [CNT_W-1:0] count_out,
    output logic             full_out
`ifdef OUTPUT_HOLDER_OVERFLOW_EN
    ,
    output logic             overflow_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             pop_req, pop_ok, push_ok;
    logic             is_full, is_empty;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // sync3 only remembers the previous sync2 so a held pin pops once
    assign pop_req = sync2_q & ~sync3_q;
    assign pop_ok  = pop_req & ~is_empty;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok = encrypted_byte_pulse_in & (~is_full | pop_ok);

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wp_q] = encrypted_byte_in;
            wp_d        = wp_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rp_d = rp_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage is not reset; count gating keeps stale contents off the pins
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            sync1_q <= read_ack_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

`ifdef OUTPUT_HOLDER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (encrypted_byte_pulse_in & ~push_ok);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_out = overflow_q;
`endif

    assign byte_out       = is_empty ? 8'h00 : mem_q[rp_q];
    assign byte_valid_out = ~is_empty;
    assign count_out      = count_q;
    assign full_out       = is_full;

endmodule

// File: tb/tb_output_holder.sv
// Directed bench for output_holder: vector table for push/pop/overflow timing, hand sequences for reset, wrap and coincident corners.
module tb_output_holder;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [7:0]       encrypted_byte_in = 8'h00;
    logic             encrypted_byte_pulse_in = 1'b0;
    logic             read_ack_in = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid_out;
    logic [CNT_W-1:0] count_out;
    logic             full_out;
    logic             ovf;

    output_holder #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .encrypted_byte_in       (encrypted_byte_in),
        .encrypted_byte_pulse_in (encrypted_byte_pulse_in),
        .read_ack_in             (read_ack_in),
        .byte_out                (byte_out),
        .byte_valid_out          (byte_valid_out),
        .count_out               (count_out),
        .full_out                (full_out)
`ifdef OUTPUT_HOLDER_OVERFLOW_EN
        ,
        .overflow_out            (ovf)
`endif
    );

`ifndef OUTPUT_HOLDER_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] dat;
        logic       ack;
        logic       vld;
        logic [7:0] bout;
        logic [2:0] cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] model[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic vld, input logic [7:0] b,
                           input int cnt, input logic full);
        chk({name, ".valid"}, 32'(byte_valid_out), 32'(vld));
        chk({name, ".byte"},  32'(byte_out), 32'(b));
        chk({name, ".count"}, 32'(count_out), 32'(cnt));
        chk({name, ".full"},  32'(full_out), 32'(full));
    endtask

    task automatic add(input logic push, input logic [7:0] d, input logic ack, input logic vld,
                       input logic [7:0] b, input logic [2:0] cnt, input logic full, input logic ov);
        vec_t v;
        v = '{push, d, ack, vld, b, cnt, full, ov};
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic push, input logic [7:0] d, input logic ack);
        encrypted_byte_pulse_in = push;
        encrypted_byte_in       = d;
        read_ack_in             = ack;
        tick();
    endtask

    task automatic push_b(input logic [7:0] d);
        apply(1'b1, d, 1'b0);
        model.push_back(d);
        chk("push.count", 32'(count_out), 32'(model.size()));
    endtask

    // Ack high two cycles then low two; the pop commits on the third edge
    task automatic pop_b();
        chk("pop.head", 32'(byte_out), 32'(model[0]));
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, 8'h00, 1'b1);
        chk("pop.before_commit", 32'(count_out), 32'(model.size()));
        apply(1'b0, 8'h00, 1'b0);
        void'(model.pop_front());
        chk("pop.count", 32'(count_out), 32'(model.size()));
        apply(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Push A5, ack rises 5 cycles later and is held for 10 cycles
        add(1, 8'hA5, 0, 1, 8'hA5, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 0, 1, 8'hA5, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'hA5, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'hA5, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        // Fill to DEPTH, fifth byte dropped
        add(1, 8'h11, 0, 1, 8'h11, 1, 0, 0);
        add(1, 8'h22, 0, 1, 8'h11, 2, 0, 0);
        add(1, 8'h33, 0, 1, 8'h11, 3, 0, 0);
        add(1, 8'h44, 0, 1, 8'h11, 4, 1, 0);
        add(1, 8'h55, 0, 1, 8'h11, 4, 1, 1);
        // Four ack pulses drain in order
        add(0, 8'h00, 1, 1, 8'h11, 4, 1, 1);
        add(0, 8'h00, 1, 1, 8'h11, 4, 1, 1);
        add(0, 8'h00, 0, 1, 8'h22, 3, 0, 1);
        add(0, 8'h00, 0, 1, 8'h22, 3, 0, 1);
        add(0, 8'h00, 1, 1, 8'h22, 3, 0, 1);
        add(0, 8'h00, 1, 1, 8'h22, 3, 0, 1);
        add(0, 8'h00, 0, 1, 8'h33, 2, 0, 1);
        add(0, 8'h00, 0, 1, 8'h33, 2, 0, 1);
        add(0, 8'h00, 1, 1, 8'h33, 2, 0, 1);
        add(0, 8'h00, 1, 1, 8'h33, 2, 0, 1);
        add(0, 8'h00, 0, 1, 8'h44, 1, 0, 1);
        add(0, 8'h00, 0, 1, 8'h44, 1, 0, 1);
        add(0, 8'h00, 1, 1, 8'h44, 1, 0, 1);
        add(0, 8'h00, 1, 1, 8'h44, 1, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);

        // Reset with pins idle
        tick();
        tick();
        chk_all("reset", 1'b0, 8'h00, 0, 1'b0);
`ifdef OUTPUT_HOLDER_OVERFLOW_EN
        chk("reset.ovf", 32'(ovf), 32'd0);
`endif
        nrst = 1'b1;
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].push, vq[i].dat, vq[i].ack);
            chk_all($sformatf("vec%0d", i), vq[i].vld, vq[i].bout, int'(vq[i].cnt), vq[i].full);
`ifdef OUTPUT_HOLDER_OVERFLOW_EN
            chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(vq[i].ovf));
`endif
        end

        // Asynchronous reset with two bytes held
        push_b(8'hC1);
        push_b(8'hC2);
        #2;
        nrst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 8'h00, 0, 1'b0);
        chk("async_rst.ovf", 32'(ovf), 32'd0);
        model.delete();
        apply(1'b0, 8'h00, 1'b0);
        nrst = 1'b1;
        apply(1'b0, 8'h00, 1'b0);
        chk_all("post_rst", 1'b0, 8'h00, 0, 1'b0);

        // Full FIFO: pop commit coincides with push of 77
        push_b(8'h81);
        push_b(8'h82);
        push_b(8'h83);
        push_b(8'h84);
        chk("full.flag", 32'(full_out), 32'd1);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b1, 8'h77, 1'b0);
        void'(model.pop_front());
        model.push_back(8'h77);
        chk_all("full_simul", 1'b1, 8'h82, 4, 1'b1);
        chk("full_simul.ovf", 32'(ovf), 32'd0);
        apply(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) pop_b();
        chk_all("full_drain", 1'b0, 8'h00, 0, 1'b0);
        chk("full_drain.ovf", 32'(ovf), 32'd0);

        // Wrap-around with occupancy at most 3
        push_b(8'h01);
        push_b(8'h02);
        push_b(8'h03);
        pop_b();
        push_b(8'h04);
        pop_b();
        push_b(8'h05);
        pop_b();
        push_b(8'h06);
        pop_b();
        pop_b();
        pop_b();
        chk_all("wrap_end", 1'b0, 8'h00, 0, 1'b0);

        // Empty FIFO: lone ack is ignored and not remembered
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 8'h00, 1'b1);
            chk("empty_ack.count", 32'(count_out), 32'd0);
        end
        for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b0);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b1, 8'h3C, 1'b0);
        chk_all("empty_simul", 1'b1, 8'h3C, 1, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b0);
        chk_all("empty_not_queued", 1'b1, 8'h3C, 1, 1'b0);
        model.push_back(8'h3C);
        pop_b();
        chk_all("final", 1'b0, 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/output_holder.md
Name: output_holder

Overview:
- Sits directly downstream of the encryption block and consumes its single-cycle encrypted-byte pulses.
- Buffers encrypted bytes in a small circular FIFO and presents the oldest byte on the chip output pins.
- An external reader pops bytes with an acknowledge pin that is asynchronous to clk.
- Gives the encryption block elastic output buffering so back-to-back encryptions are not lost while the off-chip reader is slow.

Parameters:
- DEPTH, 4, number of byte entries in the FIFO; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- encrypted_byte_in  input  8  byte from the encryption block; valid only in the pulse cycle
- encrypted_byte_pulse_in  input  1  one-cycle push strobe from the encryption block
- read_ack_in  input  1  external pop request from a pin, asynchronous; one pop per rising edge
- byte_out  output  8  head-of-FIFO byte; 8'h00 when empty
- byte_valid_out  output  1  high when the FIFO holds at least one byte
- count_out  output  CNT_W  current occupancy, 0..DEPTH
- full_out  output  1  high when count == DEPTH
- overflow_out  output  1  sticky drop flag; present only with OUTPUT_HOLDER_OVERFLOW_EN

Behaviour:
- Reset (nrst low, asynchronous):
  - read and write pointers, count and synchronizer flops cleared to 0.
  - byte_out=0, byte_valid_out=0, count_out=0, full_out=0, overflow_out=0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all buffered bytes immediately; no pop is generated by synchronizer state at reset release.
- Storage: DEPTH x 8 register array, write pointer wp and read pointer rp, each log2(DEPTH) bits.
  - Pointers wrap modulo DEPTH (natural overflow).
  - count is a separate CNT_W register.
- Push: at a rising edge with encrypted_byte_pulse_in=1:
  - if the FIFO is not full (or a pop occurs in the same cycle), mem[wp] <= encrypted_byte_in, wp++, count++.
  - Otherwise the byte is dropped and state is unchanged.
- Pop synchronizer:
  - read_ack_in passes through two flops, sync1 then sync2, followed by a history flop sync3.
  - pop_req = sync2 & ~sync3.
  - A pin rising edge meeting setup before edge E1 yields pop_req high for exactly one cycle after E2; the pop commits at E3.
  - Holding the pin high produces a single pop.
  - Pin pulses shorter than 2 clk periods are not guaranteed to be seen.
- Pop: at a rising edge with pop_req=1 and count>0, rp++ and count--. pop_req with count==0 is ignored, not queued.
- Simultaneous push and pop in the same cycle:
  - non-empty and non-full: both commit, count unchanged.
  - full: pop then push, both commit, count stays DEPTH, no drop.
  - empty: pop ignored, push commits, count=1.
- Output timing:
  - byte_out = mem[rp] when count>0, else 0.
  - byte_valid_out = (count!=0); full_out = (count==DEPTH).
  - All are combinational from registers only, with no input-to-output combinational path.
  - A push sampled at edge N is visible on byte_out/byte_valid_out after edge N.
  - After a pop, the next byte is visible after the committing edge.
- No backpressure signal goes to the encryption block; full_out is informational only.

Optional Feature:
- Macro: OUTPUT_HOLDER_OVERFLOW_EN.
- Defined:
  - overflow_out port exists.
  - Set to 1 at any edge where a push is dropped (full, no same-cycle pop).
  - Stays 1 until nrst; never cleared by pops.
- Undefined:
  - overflow_out port and its register are absent.
  - Drops are silent; all other behaviour is identical.

Test Plan:
- Reset with pins idle -> byte_out=0, byte_valid_out=0, count_out=0, full_out=0 (overflow_out=0 if enabled); assert nrst low mid-run with 2 bytes held -> all outputs return to 0 asynchronously, before the next clk edge.
- Push 8'hA5, then read_ack_in rising 5 cycles later -> byte_valid_out=1 and byte_out=8'hA5 right after the push edge; count returns to 0 on the third edge after the ack rise; ack held high for 10 cycles yields exactly one pop.
- DEPTH=4: push 11,22,33,44, then 55 -> full_out=1, count_out=4, 55 dropped (overflow_out=1 if enabled); four acks return 11,22,33,44 in order, then byte_valid_out=0.
- Wrap-around: push 6 and pop 6, interleaved so occupancy stays at most 3 -> output order matches input order across the pointer wrap, count_out=0 at end.
- Full FIFO plus pop_req in the same cycle as push 8'h77 -> no drop, count_out stays 4, 8'h77 read last (overflow_out unchanged).
- Empty FIFO, ack pulse alone -> count stays 0; ack commit coincident with push 8'h3C -> count_out=1, byte_out=8'h3C.
